// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_pkg
// Description : State type, state width and default parameters for fsm_dbnc.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_pkg;

    localparam int c_state_w = 3;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_RISE = 3'd2,
        ST_HIGH = 3'd3,
        ST_FALL = 3'd4
    } state_t;

    localparam int c_def_cnt_w     = 4;
    localparam int c_def_rise_cnt  = 3;
    localparam int c_def_fall_cnt  = 3;
    localparam int c_def_stuck_cnt = 255;

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/fsm_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : fsm_sat_cnt
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_sat_cnt #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : fsm_sat_cnt
`default_nettype wire

// File: rtl/fsm_dbnc.sv
`default_nettype none
// ============================================================================
// Module      : fsm_dbnc
// Description : Debounce / edge-qualify FSM with filtered level and edge pulses.
//               Optional HIGH-dwell 'stuck' flag built when FSM_DBNC_STUCK_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_dbnc
    import fsm_pkg::*;
#(
    parameter int CNT_W     = c_def_cnt_w,
    parameter int RISE_CNT  = c_def_rise_cnt,
    parameter int FALL_CNT  = c_def_fall_cnt,
    parameter int STUCK_CNT = c_def_stuck_cnt
) (
    input  logic                 mclk,
    input  logic                 mreset,
    input  logic                 en,
    input  logic                 a,
    output logic                 level,
    output logic                 rise_p,
    output logic                 fall_p,
    output logic [c_state_w-1:0] state_o,
    output logic                 stuck
);

    localparam logic [CNT_W-1:0] c_rise_thr = CNT_W'(RISE_CNT);
    localparam logic [CNT_W-1:0] c_fall_thr = CNT_W'(FALL_CNT);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_rise;
    logic             w_fall;
    logic             r_level;
    logic             r_rise_p;
    logic             r_fall_p;

    assign w_cnt_inc = r_cnt + c_one;

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_rise = 1'b0;
        w_fall = 1'b0;
        if (!en) begin
            // Disable wins even over a threshold reached on this edge.
            w_next = ST_IDLE;
            w_cnt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt  = '0;
                    w_next = a ? ST_HIGH : ST_LOW;
                end
                ST_LOW: begin
                    w_cnt = '0;
                    if (a) begin
                        if (c_rise_thr == c_one) begin
                            w_next = ST_HIGH;
                            w_rise = 1'b1;
                        end else begin
                            w_next = ST_RISE;
                            w_cnt  = c_one;
                        end
                    end
                end
                ST_RISE: begin
                    if (!a) begin
                        w_next = ST_LOW;
                        w_cnt  = '0;
                    end else if (w_cnt_inc == c_rise_thr) begin
                        w_next = ST_HIGH;
                        w_rise = 1'b1;
                        w_cnt  = '0;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                ST_HIGH: begin
                    w_cnt = '0;
                    if (!a) begin
                        if (c_fall_thr == c_one) begin
                            w_next = ST_LOW;
                            w_fall = 1'b1;
                        end else begin
                            w_next = ST_FALL;
                            w_cnt  = c_one;
                        end
                    end
                end
                ST_FALL: begin
                    if (a) begin
                        w_next = ST_HIGH;
                        w_cnt  = '0;
                    end else if (w_cnt_inc == c_fall_thr) begin
                        w_next = ST_LOW;
                        w_fall = 1'b1;
                        w_cnt  = '0;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                    w_cnt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (mreset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise_p <= 1'b0;
            r_fall_p <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt;
            r_level  <= (w_next == ST_HIGH) || (w_next == ST_FALL);
            r_rise_p <= w_rise;
            r_fall_p <= w_fall;
        end
    end

    assign level   = r_level;
    assign rise_p  = r_rise_p;
    assign fall_p  = r_fall_p;
    assign state_o = r_state;

`ifdef FSM_DBNC_STUCK_EN
    localparam logic [15:0] c_stuck_max = 16'(STUCK_CNT);

    logic        w_next_high;
    logic [15:0] w_dwell;
    logic        r_stuck;

    assign w_next_high = (w_next == ST_HIGH);

    // Counter holds the number of HIGH cycles so far, including the one
    // being entered, so 'stuck' lands on HIGH cycle STUCK_CNT+1.
    fsm_sat_cnt #(
        .WIDTH (16),
        .MAX   (c_stuck_max)
    ) u_dwell (
        .clk   (mclk),
        .rst   (mreset),
        .clr   (!w_next_high),
        .inc   (w_next_high),
        .count (w_dwell)
    );

    always_ff @(posedge mclk) begin
        if (mreset) begin
            r_stuck <= 1'b0;
        end else begin
            r_stuck <= w_next_high && (w_dwell == c_stuck_max);
        end
    end

    assign stuck = r_stuck;
`else
    logic w_unused_stuck;
    assign w_unused_stuck = (STUCK_CNT != 0);
    assign stuck          = 1'b0;
`endif

endmodule : fsm_dbnc
`default_nettype wire

// File: doc/fsm_dbnc.md
# fsm_dbnc

Parametrised debounce/edge-qualify state machine: tracks a single-bit input `a` through IDLE/LOW/RISE/HIGH/FALL states and reports a filtered level plus one-cycle rise/fall pulses once the input has held its new value for a programmable number of consecutive samples. It is the generalised successor of the fixed 4-bit two-way `a`-driven state machine. It sits between an already-synchronised input and control logic that needs glitch-free level and edge events. All logic is on one clock.

## Interface
Parameters:
- CNT_W, 4, width of the hold counter; RISE_CNT and FALL_CNT are legal in 1..2^CNT_W-1
- RISE_CNT, 3, consecutive `a`=1 samples required to qualify a rise
- FALL_CNT, 3, consecutive `a`=0 samples required to qualify a fall
- STUCK_CNT, 255, HIGH-state dwell cycles before `stuck` asserts; used only with FSM_DBNC_STUCK_EN; legal 1..2^16-1

Ports:
- mclk  in  1  clock; everything is on the rising edge
- mreset  in  1  reset; synchronous, active-high
- en  in  1  enable; when 0, the block returns to IDLE
- a  in  1  input, already synchronised to mclk; no internal synchroniser
- level  out  1  filtered level, registered
- rise_p  out  1  one-cycle pulse on a qualified rise
- fall_p  out  1  one-cycle pulse on a qualified fall
- state_o  out  3  current state encoding, for debug
- stuck  out  1  HIGH dwell has reached STUCK_CNT; tied to 0 when the macro is absent

## Operation
- States and encodings: IDLE=0, LOW=1, RISE=2, HIGH=3, FALL=4. Encodings 5–7 are illegal and go to IDLE on the next edge.
- IDLE: no pulses, `cnt`=0. With `en`=1, go to LOW if `a`=0 and to HIGH if `a`=1. This initial entry emits no pulse.
- LOW:
  - `a`=0: stay.
  - `a`=1 and RISE_CNT=1: go to HIGH and pulse `rise_p`.
  - `a`=1 otherwise: go to RISE with `cnt`=1.
- RISE:
  - `a`=0: return to LOW with `cnt`=0.
  - `a`=1 and `cnt`+1==RISE_CNT: go to HIGH, pulse `rise_p`, set `cnt`=0.
  - `a`=1 otherwise: `cnt`++.
- HIGH/FALL: mirror of LOW/RISE, using `a`=0, FALL_CNT and `fall_p`.
- `level` is 1 in HIGH and FALL, and 0 in IDLE, LOW and RISE.
- `en`=0 in any state: next state is IDLE and `cnt` clears. No pulse is emitted, even if the threshold would have been reached on that edge; `en` has priority.
- The counter never wraps: thresholds bound it to at most RISE_CNT-1 or FALL_CNT-1.

## Timing
- All outputs are registered.
- Reset values: `level`=0, `rise_p`=0, `fall_p`=0, `state_o`=0 (IDLE), `stuck`=0, internal `cnt`=0.
- Reset mid-operation returns the block to IDLE on the same edge, with outputs as listed above, overriding `en` and `a`.
- Latency: suppose the first `a`=1 sample in LOW is taken at edge k and `a` stays 1. Then `rise_p`=1 and `level`=1 in the cycle following edge k+RISE_CNT-1. Falls are symmetric, using FALL_CNT.
- Pulses are exactly one cycle wide. `rise_p` and `fall_p` are never asserted together.
- After a pulse, at least one cycle passes before the opposite pulse can occur.

## Configuration
- Macro: `FSM_DBNC_STUCK_EN`.
- When defined:
  - A 16-bit dwell counter increments on every HIGH cycle and saturates at STUCK_CNT.
  - `stuck` is registered and asserts in the cycle after the counter reaches STUCK_CNT.
  - Entering any state other than HIGH clears both the counter and `stuck` on that edge; this includes HIGH→FALL.
- When undefined: no dwell counter is built, `stuck` is constant 0, and STUCK_CNT is ignored.

## Structure
- Package `fsm_pkg` holds:
  - the 3-bit state typedef and the five state constants;
  - the state width constant (3);
  - the default-parameter constants.
- One sub-module, `fsm_sat_cnt`: a parametrised-width saturating up-counter with synchronous clear. It is used for the dwell counter, and may also serve as the hold counter.

## Test plan
- Reset: hold `mreset`=1 for 2 cycles with `a`=1 → all outputs 0, `state_o`=0. Release with `en`=1, `a`=1 → HIGH on the next edge, `level`=1, no `rise_p`.
- Clean rise (RISE_CNT=3): in LOW, drive `a`=1 for 5 cycles → `rise_p` is a single pulse exactly 3 cycles after the first high sample; `level` rises in that same cycle.
- Glitch reject (RISE_CNT=3): in LOW, drive `a`=1,1,0,1,1,1 → RISE aborts to LOW after the `a`=0 sample; `rise_p` fires only 3 cycles after the final run starts.
- Threshold 1 (RISE_CNT=FALL_CNT=1): toggle `a` every 2 cycles → `rise_p` and `fall_p` alternate, each 1 cycle after the input edge, never overlapping.
- Disable mid-qualify: in RISE with `cnt`=2 and RISE_CNT=3, set `en`=0 while `a`=1 → IDLE next edge, no `rise_p`, `level` stays 0.
- Stuck (macro defined, STUCK_CNT=4): in HIGH, hold `a`=1 → `stuck`=1 on the 5th HIGH cycle. Drive `a`=0 → `stuck`=0 at the HIGH→FALL edge.
